// File: rtl/wta_round_ctrl_if.sv
// Handshake bundle between the SPI-side sequencer and the WTA round controller.
// Signal names keep their direction prefixes as seen from the controller.
interface wta_round_ctrl_if #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned TMO_W = 12
);
    logic                    i_start;
    logic                    i_abort;
    logic [IDX_W-1:0]        i_k;
    logic [TMO_W-1:0]        i_timeout;
    logic [N_CH-1:0]         i_fall;

    logic                    o_pwm_tri;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_timeout;
    logic [N_CH-1:0]         o_win_mask;
    logic [IDX_W:0]          o_count;
    logic [N_CH*IDX_W-1:0]   o_order;
    logic [IDX_W-1:0]        o_first;
    logic [TMO_W-1:0]        o_elapsed;

    modport master (
        output i_start, i_abort, i_k, i_timeout, i_fall,
        input  o_pwm_tri, o_busy, o_done, o_timeout, o_win_mask, o_count, o_order, o_first,
               o_elapsed
    );

    modport slave (
        input  i_start, i_abort, i_k, i_timeout, i_fall,
        output o_pwm_tri, o_busy, o_done, o_timeout, o_win_mask, o_count, o_order, o_first,
               o_elapsed
    );
endinterface

// File: rtl/wta_round_ctrl.sv
// Winner-take-all / k-NN round sequencer: triggers the PWM generators, then ranks
// channels by first falling edge until K winners, all channels, or timeout.
module wta_round_ctrl #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned TMO_W = 12
) (
    input logic             clk,
    input logic             rst,
    wta_round_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StTrig, StRun, StDone} state_e;

    state_e                  state_q, state_d;
    logic [N_CH-1:0]         mask_q, mask_d;
    logic [IDX_W:0]          count_q, count_d;
    logic [IDX_W:0]          k_eff_q, k_eff_d;
    logic [N_CH*IDX_W-1:0]   order_q, order_d;
    logic [TMO_W-1:0]        timer_q, timer_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [TMO_W-1:0]        elapsed_q, elapsed_d;
    logic                    tmo_flag_q, tmo_flag_d;

    logic [N_CH-1:0]         fall_new;
    logic [IDX_W-1:0]        slot_idx;
    logic [TMO_W-1:0]        timer_inc;
    logic                    cnt_hit;
    logic                    all_hit;
    logic                    tmo_hit;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        count_d    = count_q;
        k_eff_d    = k_eff_q;
        order_d    = order_q;
        timer_d    = timer_q;
        tmo_d      = tmo_q;
        elapsed_d  = elapsed_q;
        tmo_flag_d = tmo_flag_q;
        fall_new   = '0;
        slot_idx   = count_q[IDX_W-1:0];
        timer_inc  = timer_q + TMO_W'(1);
        cnt_hit    = 1'b0;
        all_hit    = 1'b0;
        tmo_hit    = 1'b0;

        if (bus.i_abort) begin
            // Partial results stay visible; only the sequencing is dropped.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        state_d    = StTrig;
                        mask_d     = '0;
                        count_d    = '0;
                        order_d    = '0;
                        elapsed_d  = '0;
                        tmo_flag_d = 1'b0;
                        k_eff_d    = (bus.i_k == '0) ? (IDX_W+1)'(N_CH) : {1'b0, bus.i_k};
                        tmo_d      = bus.i_timeout;
                    end
                end
                StTrig: begin
                    state_d = StRun;
                    timer_d = '0;
                end
                StRun: begin
                    fall_new = bus.i_fall & ~mask_q;
                    // Same-cycle ties take consecutive slots, lowest channel first.
                    for (int i = 0; i < N_CH; i++) begin
                        if (fall_new[i]) begin
                            order_d[slot_idx*IDX_W +: IDX_W] = IDX_W'(i);
                            slot_idx = slot_idx + IDX_W'(1);
                            count_d  = count_d + (IDX_W+1)'(1);
                        end
                    end
                    mask_d  = mask_q | fall_new;
                    timer_d = (&timer_q) ? timer_q : timer_inc;

                    cnt_hit = (count_d >= k_eff_q);
                    all_hit = &mask_d;
                    tmo_hit = (tmo_q != '0) && (timer_inc == tmo_q);

                    if (cnt_hit || all_hit || tmo_hit) begin
                        state_d    = StDone;
                        elapsed_d  = timer_d;
                        tmo_flag_d = tmo_hit && !cnt_hit && !all_hit;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            count_q    <= '0;
            k_eff_q    <= '0;
            order_q    <= '0;
            timer_q    <= '0;
            tmo_q      <= '0;
            elapsed_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            k_eff_q    <= k_eff_d;
            order_q    <= order_d;
            timer_q    <= timer_d;
            tmo_q      <= tmo_d;
            elapsed_q  <= elapsed_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    // Control outputs decode straight from the state register, so they are glitch-free.
    assign bus.o_pwm_tri  = (state_q == StTrig);
    assign bus.o_busy     = (state_q == StTrig) || (state_q == StRun);
    assign bus.o_done     = (state_q == StDone);
    assign bus.o_timeout  = tmo_flag_q;
    assign bus.o_win_mask = mask_q;
    assign bus.o_count    = count_q;
    assign bus.o_order    = order_q;
    assign bus.o_first    = order_q[IDX_W-1:0];
    assign bus.o_elapsed  = elapsed_q;

endmodule

// File: tb/tb_wta_round_ctrl.sv
// Directed bench for wta_round_ctrl: expected round results are queued when a round
// is launched and checked when the DUT pulses o_done.
module tb_wta_round_ctrl;

    typedef struct {
        logic [7:0]  mask;
        logic [3:0]  count;
        logic [23:0] order;
        logic [2:0]  first;
        logic [11:0] elapsed;
        logic        tmo;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];
    exp_t mon_e;

    wta_round_ctrl_if #(.N_CH(8), .IDX_W(3), .TMO_W(12)) bus ();

    wta_round_ctrl #(.N_CH(8), .IDX_W(3), .TMO_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] m);
        bus.i_fall = m;
        step();
        bus.i_fall = '0;
    endtask

    task automatic expect_round(input logic [7:0] mask, input logic [3:0] count,
                                input logic [23:0] order, input logic [2:0] first,
                                input logic [11:0] elapsed, input logic tmo);
        exp_t e;
        e.mask    = mask;
        e.count   = count;
        e.order   = order;
        e.first   = first;
        e.elapsed = elapsed;
        e.tmo     = tmo;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pwm_tri"},  32'(bus.o_pwm_tri),  0);
        chk({tag, "_busy"},     32'(bus.o_busy),     0);
        chk({tag, "_done"},     32'(bus.o_done),     0);
        chk({tag, "_timeout"},  32'(bus.o_timeout),  0);
        chk({tag, "_win_mask"}, 32'(bus.o_win_mask), 0);
        chk({tag, "_count"},    32'(bus.o_count),    0);
        chk({tag, "_order"},    32'(bus.o_order),    0);
        chk({tag, "_first"},    32'(bus.o_first),    0);
        chk({tag, "_elapsed"},  32'(bus.o_elapsed),  0);
    endtask

    // Start sampled at the next edge; afterwards the DUT sits in TRIG.
    task automatic start_round(input logic [2:0] k, input logic [11:0] tmo);
        bus.i_k       = k;
        bus.i_timeout = tmo;
        bus.i_start   = 1'b1;
        step();
        bus.i_start   = 1'b0;
        chk("trig_pulse", 32'(bus.o_pwm_tri), 1);
        chk("trig_busy",  32'(bus.o_busy),    1);
        chk("trig_clear", 32'(bus.o_count),   0);
    endtask

    always @(negedge clk) begin
        if (bus.o_done === 1'b1) begin
            chk("done_has_expect", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("res_mask",    32'(bus.o_win_mask), 32'(mon_e.mask));
                chk("res_count",   32'(bus.o_count),    32'(mon_e.count));
                chk("res_order",   32'(bus.o_order),    32'(mon_e.order));
                chk("res_first",   32'(bus.o_first),    32'(mon_e.first));
                chk("res_elapsed", 32'(bus.o_elapsed),  32'(mon_e.elapsed));
                chk("res_timeout", 32'(bus.o_timeout),  32'(mon_e.tmo));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_abort   = 1'b0;
        bus.i_k       = '0;
        bus.i_timeout = '0;
        bus.i_fall    = '0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Ordered arrival, with an all-channel fall during TRIG that must be ignored.
        start_round(3'd3, 12'd0);
        bus.i_fall = 8'hFF;
        step();
        bus.i_fall = '0;
        chk("trig_fall_ignored_cnt",  32'(bus.o_count),    0);
        chk("trig_fall_ignored_mask", 32'(bus.o_win_mask), 0);
        chk("run_no_tri",             32'(bus.o_pwm_tri),  0);
        expect_round(8'hA4, 4'd3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd2, 3'd5},
                     3'd5, 12'd3, 1'b0);
        pulse(8'h20);
        pulse(8'h04);
        chk("ordered_not_done", 32'(bus.o_done), 0);
        pulse(8'h80);
        chk("ordered_done", 32'(bus.o_done), 1);
        step();
        chk("ordered_done_1cyc", 32'(bus.o_done), 0);
        chk("ordered_idle_busy", 32'(bus.o_busy), 0);
        chk("ordered_hold_cnt",  32'(bus.o_count), 3);

        // Same-cycle tie with overshoot past K=2.
        start_round(3'd2, 12'd0);
        step();
        expect_round(8'h4A, 4'd3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd3, 3'd1},
                     3'd1, 12'd1, 1'b0);
        pulse(8'h4A);
        chk("tie_done", 32'(bus.o_done), 1);
        step();

        // Timeout after exactly 10 RUN cycles with a single capture.
        start_round(3'd4, 12'd10);
        step();
        expect_round(8'h01, 4'd1, 24'd0, 3'd0, 12'd10, 1'b1);
        pulse(8'h01);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("tmo_no_early_done", 32'(bus.o_done), 0);
        end
        step();
        chk("tmo_done", 32'(bus.o_done), 1);
        step();

        // Default K with each channel pulsing twice, staggered 7..0.
        start_round(3'd0, 12'd0);
        step();
        expect_round(8'hFF, 4'd8, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
                     3'd7, 12'd8, 1'b0);
        pulse(8'h80);
        pulse(8'hC0);
        pulse(8'h60);
        pulse(8'h30);
        pulse(8'h18);
        pulse(8'h0C);
        pulse(8'h06);
        pulse(8'h03);
        chk("allk_done", 32'(bus.o_done), 1);
        pulse(8'h01);
        chk("allk_hold_cnt", 32'(bus.o_count), 8);

        // Start held through RUN; i_k changed mid-round; then back-to-back restart.
        bus.i_k     = 3'd1;
        bus.i_start = 1'b1;
        step();
        chk("held_trig", 32'(bus.o_pwm_tri), 1);
        bus.i_k = 3'd4;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_no_retrig", 32'(bus.o_pwm_tri), 0);
            chk("held_busy",      32'(bus.o_busy),    1);
        end
        expect_round(8'h10, 4'd1, 24'd4, 3'd4, 12'd4, 1'b0);
        pulse(8'h10);
        chk("held_done", 32'(bus.o_done), 1);
        step();
        chk("b2b_idle", 32'(bus.o_busy), 0);
        step();
        chk("b2b_trig",  32'(bus.o_pwm_tri),  1);
        chk("b2b_clear", 32'(bus.o_win_mask), 0);
        bus.i_start = 1'b0;
        step();

        // Abort after two captures: no done, partial result retained.
        pulse(8'h03);
        step();
        bus.i_abort = 1'b1;
        step();
        bus.i_abort = 1'b0;
        chk("abort_busy",  32'(bus.o_busy),     0);
        chk("abort_done",  32'(bus.o_done),     0);
        chk("abort_count", 32'(bus.o_count),    2);
        chk("abort_mask",  32'(bus.o_win_mask), 3);
        chk("abort_order", 32'(bus.o_order),    8);
        chk("abort_tmo",   32'(bus.o_timeout),  0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", 32'(bus.o_done), 0);
        end

        // Synchronous reset mid-RUN, then a fresh round.
        start_round(3'd0, 12'd0);
        step();
        pulse(8'h01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("midrst");
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("post_rst_trig", 32'(bus.o_pwm_tri), 1);
        step();
        chk("post_rst_run", 32'(bus.o_pwm_tri), 0);
        expect_round(8'hFF, 4'd8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                     3'd0, 12'd1, 1'b0);
        pulse(8'hFF);
        chk("post_rst_done", 32'(bus.o_done), 1);
        step();
        step();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
